// File: rtl/mem_bus_pkg.sv
// Shared definitions for the single-word memory bus: access sizes, master FSM
// states, idle address and the alignment rule applied at acceptance.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WR     = 3'd3,
        ST_RMW_WR = 3'd4
    } state_e;

    localparam logic [31:0] IDLE_ADDR_DEFAULT = 32'h0800_0000;

    // High when the size code is reserved or the address is not naturally aligned.
    function automatic logic access_fault(input size_e size, input logic [1:0] addr_lo);
        logic fault_v;
        case (size)
            SIZE_BYTE: fault_v = 1'b0;
            SIZE_HALF: fault_v = addr_lo[0];
            SIZE_WORD: fault_v = (addr_lo != 2'b00);
            default:   fault_v = 1'b1;
        endcase
        return fault_v;
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Little-endian lane handling: merges store lanes into a word and extracts
// sign/zero-extended sub-word load data.
module mem_lane_merge
    import mem_bus_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  size_e       size,
    input  logic [1:0]  addr_lo,
    input  logic        is_signed,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    // Replace only the addressed byte or halfword lane of the read word.
    always_comb begin
        merged = word;
        case (size)
            SIZE_BYTE: begin
                case (addr_lo)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (addr_lo[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            default: merged = word;
        endcase
    end

    // Word data passes through untouched so Z/X from unmapped space stays visible.
    always_comb begin
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        case (addr_lo)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        if (addr_lo[1]) begin
            half_v = word[31:16];
        end else begin
            half_v = word[15:0];
        end
        case (size)
            SIZE_BYTE: extracted = {{24{is_signed & byte_v[7]}}, byte_v};
            SIZE_HALF: extracted = {{16{is_signed & half_v[15]}}, half_v};
            default:   extracted = word;
        endcase
    end

endmodule

// File: rtl/mem_bus_master.sv
// Bus initiator: arbitrates fetch and load/store onto the single-word bus,
// performs read-modify-write for sub-word stores and reports alignment faults.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter bit          DATA_PRIORITY = 1'b1,
    parameter logic [31:0] IDLE_ADDR     = IDLE_ADDR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ack,
    output logic [31:0] fetch_instr,
    output logic        fetch_fault,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_signed,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic        ls_fault,
    output logic [31:0] bus_address,
    output logic [31:0] bus_wdata,
    output logic        bus_write_enable,
    input  logic [31:0] bus_rdata
);

    state_e      state_r, state_s;
    logic        is_fetch_r, is_fetch_s;
    logic        fault_r, fault_s;
    size_e       size_r, size_s;
    logic        signed_r, signed_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] wdata_r, wdata_s;

    logic [31:0] bus_address_r, bus_address_s;
    logic [31:0] bus_wdata_r, bus_wdata_s;
    logic        bus_we_r, bus_we_s;
    logic        fetch_ack_r, fetch_ack_s;
    logic        fetch_fault_r, fetch_fault_s;
    logic [31:0] fetch_instr_r, fetch_instr_s;
    logic        ls_ack_r, ls_ack_s;
    logic        ls_fault_r, ls_fault_s;
    logic [31:0] ls_rdata_r, ls_rdata_s;

    logic        grant_ls_s;
    logic [31:0] merged_s;
    logic [31:0] extracted_s;

    mem_lane_merge u_lane (
        .word      (bus_rdata),
        .wdata     (wdata_r),
        .size      (size_r),
        .addr_lo   (addr_r[1:0]),
        .is_signed (signed_r),
        .merged    (merged_s),
        .extracted (extracted_s)
    );

    // Next state, latched request attributes and next values of every output register.
    always_comb begin
        state_s       = state_r;
        is_fetch_s    = is_fetch_r;
        fault_s       = fault_r;
        size_s        = size_r;
        signed_s      = signed_r;
        addr_s        = addr_r;
        wdata_s       = wdata_r;
        bus_address_s = IDLE_ADDR;
        bus_wdata_s   = 32'h0000_0000;
        bus_we_s      = 1'b0;
        fetch_ack_s   = 1'b0;
        fetch_fault_s = 1'b0;
        fetch_instr_s = fetch_instr_r;
        ls_ack_s      = 1'b0;
        ls_fault_s    = 1'b0;
        ls_rdata_s    = ls_rdata_r;
        grant_ls_s    = ls_req & (DATA_PRIORITY | ~fetch_req);

        case (state_r)
            ST_IDLE: begin
                if (grant_ls_s) begin
                    is_fetch_s = 1'b0;
                    size_s     = size_e'(ls_size);
                    signed_s   = ls_signed;
                    addr_s     = ls_addr;
                    wdata_s    = ls_wdata;
                    fault_s    = access_fault(size_e'(ls_size), ls_addr[1:0]);
                    // Faulting accesses pass through RD with the bus left idle.
                    if (fault_s) begin
                        state_s = ST_RD;
                    end else if (!ls_we) begin
                        state_s       = ST_RD;
                        bus_address_s = {ls_addr[31:2], 2'b00};
                    end else if (ls_size == SIZE_WORD) begin
                        state_s       = ST_WR;
                        bus_address_s = {ls_addr[31:2], 2'b00};
                        bus_wdata_s   = ls_wdata;
                        bus_we_s      = 1'b1;
                    end else begin
                        state_s       = ST_RMW_RD;
                        bus_address_s = {ls_addr[31:2], 2'b00};
                    end
                end else if (fetch_req) begin
                    is_fetch_s = 1'b1;
                    size_s     = SIZE_WORD;
                    signed_s   = 1'b0;
                    addr_s     = fetch_addr;
                    wdata_s    = 32'h0000_0000;
                    fault_s    = (fetch_addr[1:0] != 2'b00);
                    state_s    = ST_RD;
                    if (!fault_s) begin
                        bus_address_s = {fetch_addr[31:2], 2'b00};
                    end else begin
                        bus_address_s = IDLE_ADDR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                state_s = ST_IDLE;
                if (is_fetch_r) begin
                    fetch_ack_s   = 1'b1;
                    fetch_fault_s = fault_r;
                    if (!fault_r) begin
                        fetch_instr_s = bus_rdata;
                    end else begin
                        fetch_instr_s = fetch_instr_r;
                    end
                end else begin
                    ls_ack_s   = 1'b1;
                    ls_fault_s = fault_r;
                    if (!fault_r) begin
                        ls_rdata_s = extracted_s;
                    end else begin
                        ls_rdata_s = ls_rdata_r;
                    end
                end
            end
            ST_RMW_RD: begin
                state_s       = ST_RMW_WR;
                bus_address_s = {addr_r[31:2], 2'b00};
                bus_wdata_s   = merged_s;
                bus_we_s      = 1'b1;
            end
            ST_WR, ST_RMW_WR: begin
                state_s  = ST_IDLE;
                ls_ack_s = 1'b1;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and latched attributes of the accepted request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            is_fetch_r <= 1'b0;
            fault_r    <= 1'b0;
            size_r     <= SIZE_WORD;
            signed_r   <= 1'b0;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
        end else begin
            state_r    <= state_s;
            is_fetch_r <= is_fetch_s;
            fault_r    <= fault_s;
            size_r     <= size_s;
            signed_r   <= signed_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
        end
    end

    // Output registers; reset drops write_enable immediately, mid-transfer included.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_address_r <= IDLE_ADDR;
            bus_wdata_r   <= 32'h0000_0000;
            bus_we_r      <= 1'b0;
            fetch_ack_r   <= 1'b0;
            fetch_fault_r <= 1'b0;
            fetch_instr_r <= 32'h0000_0000;
            ls_ack_r      <= 1'b0;
            ls_fault_r    <= 1'b0;
            ls_rdata_r    <= 32'h0000_0000;
        end else begin
            bus_address_r <= bus_address_s;
            bus_wdata_r   <= bus_wdata_s;
            bus_we_r      <= bus_we_s;
            fetch_ack_r   <= fetch_ack_s;
            fetch_fault_r <= fetch_fault_s;
            fetch_instr_r <= fetch_instr_s;
            ls_ack_r      <= ls_ack_s;
            ls_fault_r    <= ls_fault_s;
            ls_rdata_r    <= ls_rdata_s;
        end
    end

    assign bus_address      = bus_address_r;
    assign bus_wdata        = bus_wdata_r;
    assign bus_write_enable = bus_we_r;
    assign fetch_ack        = fetch_ack_r;
    assign fetch_fault      = fetch_fault_r;
    assign fetch_instr      = fetch_instr_r;
    assign ls_ack           = ls_ack_r;
    assign ls_fault         = ls_fault_r;
    assign ls_rdata         = ls_rdata_r;

endmodule
